// File: rtl/fft_iter_pkg.sv
// Shared definitions for the iterative radix-2 FFT datapath.
// Holds the default FFT geometry (also reused by the control unit), a clog2 helper
// and the in-place DIT butterfly address decode as a function.
// Contents:
//   DefLayers/DefButterflyes/DefLayWL/DefButtWL  default FFT geometry (N = 32)
//   AddrWL                                       data RAM address width for the defaults
//   clog2(v)                                     ceiling log2
//   addr_decode(layers, l, b)                    {A, B, TW} for layer l, butterfly b
package fft_iter_pkg;

  localparam int unsigned DefLayers      = 5;
  localparam int unsigned DefButterflyes = 16;
  localparam int unsigned DefLayWL       = 3;
  localparam int unsigned DefButtWL      = 4;
  localparam int unsigned AddrWL         = DefButtWL + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] tw;
  } fft_dec_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Evaluated at 32 bits; callers truncate to their address width, which is exact
  // because only left shifts and ORs feed the upper bits.
  function automatic fft_dec_t addr_decode(input logic [31:0] layers, input logic [31:0] l,
                                           input logic [31:0] b);
    logic [31:0] span;
    logic [31:0] idx;
    logic [31:0] grp;
    fft_dec_t    d;
    span = 32'd1 << l;
    idx  = b & (span - 32'd1);
    grp  = b >> l;
    d.a  = (grp << (l + 32'd1)) | idx;
    d.b  = d.a | span;
    d.tw = (l < layers) ? (idx << (layers - 32'd1 - l)) : 32'd0;
    return d;
  endfunction

endpackage

// File: rtl/fft_butt_addr_decode.sv
// Combinational in-place DIT butterfly address decode.
// Ports:
//   i_lay   layer index l
//   i_butt  butterfly index b within the layer
//   o_a     upper butterfly RAM address
//   o_b     lower butterfly RAM address (o_a | 1<<l)
//   o_tw    twiddle ROM index
module fft_butt_addr_decode
  import fft_iter_pkg::*;
#(
  parameter int unsigned LAYERS = DefLayers,
  parameter int unsigned LayWL  = DefLayWL,
  parameter int unsigned ButtWL = DefButtWL
) (
  input  logic [LayWL-1:0]  i_lay,
  input  logic [ButtWL-1:0] i_butt,
  output logic [ButtWL:0]   o_a,
  output logic [ButtWL:0]   o_b,
  output logic [ButtWL-1:0] o_tw
);

  fft_dec_t w_dec;
  logic     w_unused_dec;

  assign w_dec = addr_decode(32'(LAYERS), 32'(i_lay), 32'(i_butt));
  assign o_a   = w_dec.a[ButtWL:0];
  assign o_b   = w_dec.b[ButtWL:0];
  assign o_tw  = w_dec.tw[ButtWL-1:0];

  // Upper bits are always zero for legal counters; truncation is intentional.
  assign w_unused_dec = ^{w_dec.a[31:ButtWL+1], w_dec.b[31:ButtWL+1], w_dec.tw[31:ButtWL]};

endmodule

// File: rtl/fft_iter_addr_gen.sv
// Address generator for the iterative radix-2 DIT FFT.
// Walks butterfly/layer counters on ADDR_EN strobes from the control unit and presents
// registered in-place read/write addresses, the twiddle index and layer status.
// Optional feature: define FFT_ADDR_LAYCHK_EN to cross-check the control unit's LAY_EN
// pulse against the internal layer wrap (sticky LAY_ERR); otherwise LAY_ERR is 0.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   i_EN                        global enable (low holds all state)
//   i_ADDR_RST                  clear counters
//   i_ADDR_EN                   advance one butterfly
//   i_LAY_EN                    control unit layer pulse (checked only with the macro)
//   i_Wr                        write cycle qualifier
//   o_ADDR_A_RD/o_ADDR_B_RD     butterfly read addresses
//   o_ADDR_A_WR/o_ADDR_B_WR     butterfly write addresses (same pair, in-place)
//   o_TW_ADDR                   twiddle ROM index
//   o_WE                        RAM write enable (i_Wr & i_EN)
//   o_LAY_NUM, o_LAST_LAY       current layer, final-layer flag
//   o_DONE                      one-cycle pulse after the final butterfly
//   o_LAY_ERR                   sticky layer-sync error
module fft_iter_addr_gen
  import fft_iter_pkg::*;
#(
  parameter int unsigned LAYERS      = DefLayers,
  parameter int unsigned BUTTERFLYES = DefButterflyes,
  parameter int unsigned LayWL       = DefLayWL,
  parameter int unsigned ButtWL      = DefButtWL
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_EN,
  input  logic              i_ADDR_RST,
  input  logic              i_ADDR_EN,
  input  logic              i_LAY_EN,
  input  logic              i_Wr,
  output logic [ButtWL:0]   o_ADDR_A_RD,
  output logic [ButtWL:0]   o_ADDR_B_RD,
  output logic [ButtWL-1:0] o_TW_ADDR,
  output logic [ButtWL:0]   o_ADDR_A_WR,
  output logic [ButtWL:0]   o_ADDR_B_WR,
  output logic              o_WE,
  output logic [LayWL-1:0]  o_LAY_NUM,
  output logic              o_LAST_LAY,
  output logic              o_DONE,
  output logic              o_LAY_ERR
);

  logic [ButtWL-1:0] r_butt_cnt, w_butt_nxt;
  logic [LayWL-1:0]  r_lay_cnt, w_lay_nxt;
  logic              r_done, w_done_nxt;
  logic [ButtWL:0]   r_addr_a, r_addr_b, w_a_nxt, w_b_nxt;
  logic [ButtWL-1:0] r_tw, w_tw_nxt;
  logic              r_last_lay;
  logic              w_butt_last, w_lay_last;

  assign w_butt_last = (r_butt_cnt == ButtWL'(BUTTERFLYES - 1));
  assign w_lay_last  = (r_lay_cnt == LayWL'(LAYERS - 1));

  always_comb begin
    w_butt_nxt = r_butt_cnt;
    w_lay_nxt  = r_lay_cnt;
    w_done_nxt = r_done;
    if (RST || i_ADDR_RST) begin
      w_butt_nxt = '0;
      w_lay_nxt  = '0;
      w_done_nxt = 1'b0;
    end else if (i_EN) begin
      w_done_nxt = 1'b0;
      if (i_ADDR_EN) begin
        if (w_butt_last) begin
          w_butt_nxt = '0;
          if (w_lay_last) begin
            w_lay_nxt  = '0;
            w_done_nxt = 1'b1;
          end else begin
            w_lay_nxt = r_lay_cnt + LayWL'(1);
          end
        end else begin
          w_butt_nxt = r_butt_cnt + ButtWL'(1);
        end
      end
    end
  end

  // Decoding the next-state counters lets the address flops track the counters
  // with no visible latency; a reset reloads decode(0,0), i.e. A=0, B=1.
  fft_butt_addr_decode #(
    .LAYERS (LAYERS),
    .LayWL  (LayWL),
    .ButtWL (ButtWL)
  ) u_decode (
    .i_lay  (w_lay_nxt),
    .i_butt (w_butt_nxt),
    .o_a    (w_a_nxt),
    .o_b    (w_b_nxt),
    .o_tw   (w_tw_nxt)
  );

  always_ff @(posedge CLK) begin
    r_butt_cnt <= w_butt_nxt;
    r_lay_cnt  <= w_lay_nxt;
    r_done     <= w_done_nxt;
    r_addr_a   <= w_a_nxt;
    r_addr_b   <= w_b_nxt;
    r_tw       <= w_tw_nxt;
    r_last_lay <= (w_lay_nxt == LayWL'(LAYERS - 1));
  end

`ifdef FFT_ADDR_LAYCHK_EN
  logic r_lay_err;
  logic w_wrap, w_err_set;

  assign w_wrap    = i_EN & i_ADDR_EN & ~i_ADDR_RST & w_butt_last;
  // LAY_EN without a wrap, or a wrap into a non-zero layer without LAY_EN.
  assign w_err_set = i_EN & ((i_LAY_EN & ~w_wrap) | (w_wrap & ~w_lay_last & ~i_LAY_EN));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lay_err <= 1'b0;
    end else if (w_err_set) begin
      r_lay_err <= 1'b1;
    end
  end

  assign o_LAY_ERR = r_lay_err;
`else
  logic w_unused_lay_en;
  assign w_unused_lay_en = i_LAY_EN;
  assign o_LAY_ERR       = 1'b0;
`endif

  assign o_ADDR_A_RD = r_addr_a;
  assign o_ADDR_B_RD = r_addr_b;
  assign o_ADDR_A_WR = r_addr_a;
  assign o_ADDR_B_WR = r_addr_b;
  assign o_TW_ADDR   = r_tw;
  assign o_WE        = i_Wr & i_EN;
  assign o_LAY_NUM   = r_lay_cnt;
  assign o_LAST_LAY  = r_last_lay;
  assign o_DONE      = r_done;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Self-checking bench for fft_iter_addr_gen at LAYERS=3, BUTTERFLYES=4.
// Vector table, hand-written wrap/LAY_ERR sequences, then randomized strobes against
// a model that tracks a flat butterfly index and derives addresses arithmetically.
module tb_fft_iter_addr_gen;

  localparam int L   = 3;
  localparam int BF  = 4;
  localparam int BWL = 2;
  localparam int LWL = 2;
`ifdef FFT_ADDR_LAYCHK_EN
  localparam bit LayChk = 1'b1;
`else
  localparam bit LayChk = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           en = 1'b0, ar = 1'b0, ae = 1'b0, le = 1'b0, wr = 1'b0;
  logic [BWL:0]   a_rd, b_rd, a_wr, b_wr;
  logic [BWL-1:0] tw;
  logic           we, last_lay, done, lay_err;
  logic [LWL-1:0] lay_num;

  int checks = 0;
  int errors = 0;

  fft_iter_addr_gen #(
    .LAYERS      (L),
    .BUTTERFLYES (BF),
    .LayWL       (LWL),
    .ButtWL      (BWL)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_EN        (en),
    .i_ADDR_RST  (ar),
    .i_ADDR_EN   (ae),
    .i_LAY_EN    (le),
    .i_Wr        (wr),
    .o_ADDR_A_RD (a_rd),
    .o_ADDR_B_RD (b_rd),
    .o_TW_ADDR   (tw),
    .o_ADDR_A_WR (a_wr),
    .o_ADDR_B_WR (b_wr),
    .o_WE        (we),
    .o_LAY_NUM   (lay_num),
    .o_LAST_LAY  (last_lay),
    .o_DONE      (done),
    .o_LAY_ERR   (lay_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic en, ar, ae, wr, le;
    int   a, b, tw, lay;
    logic last, done, we;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ea, input int eb, input int etw,
                           input int elay, input logic elast, input logic edone,
                           input logic ewe, input logic eerr);
    check({tag, " A_RD"}, 32'(a_rd), ea);
    check({tag, " B_RD"}, 32'(b_rd), eb);
    check({tag, " A_WR"}, 32'(a_wr), ea);
    check({tag, " B_WR"}, 32'(b_wr), eb);
    check({tag, " TW"}, 32'(tw), etw);
    check({tag, " LAY_NUM"}, 32'(lay_num), elay);
    check({tag, " LAST_LAY"}, 32'(last_lay), 32'(elast));
    check({tag, " DONE"}, 32'(done), 32'(edone));
    check({tag, " WE"}, 32'(we), 32'(ewe));
    check({tag, " LAY_ERR"}, 32'(lay_err), 32'(eerr));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic step(input logic s_en, input logic s_ar, input logic s_ae, input logic s_wr,
                      input logic s_le);
    @(negedge CLK);
    en = s_en; ar = s_ar; ae = s_ae; wr = s_wr; le = s_le;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; en = 1'b1; ar = 1'b0; ae = 1'b0; wr = 1'b0; le = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Reference addresses from a flat butterfly index t = layer*BF + butterfly.
  task automatic model_addr(input int t, output int ma, output int mb, output int mtw,
                            output int mlay);
    int bb, span, idx, grp;
    mlay = t / BF;
    bb   = t % BF;
    span = 2 ** mlay;
    idx  = bb % span;
    grp  = bb / span;
    ma   = grp * 2 * span + idx;
    mb   = ma + span;
    mtw  = idx * (2 ** (L - 1 - mlay));
  endtask

  initial begin
    int t, ma, mb, mtw, mlay;
    bit mdone, merr, wrap;

    //          en ar ae wr le   A  B  TW lay last done we
    vecs[0]  = '{1, 1, 0, 0, 0,  0, 1, 0, 0,  0,  0,  0};
    vecs[1]  = '{1, 0, 1, 1, 0,  2, 3, 0, 0,  0,  0,  1};
    vecs[2]  = '{1, 0, 1, 1, 0,  4, 5, 0, 0,  0,  0,  1};
    vecs[3]  = '{1, 0, 1, 0, 0,  6, 7, 0, 0,  0,  0,  0};
    vecs[4]  = '{1, 0, 1, 1, 1,  0, 2, 0, 1,  0,  0,  1};
    vecs[5]  = '{1, 0, 1, 1, 0,  1, 3, 2, 1,  0,  0,  1};
    vecs[6]  = '{0, 0, 1, 1, 0,  1, 3, 2, 1,  0,  0,  0};
    vecs[7]  = '{0, 0, 1, 1, 0,  1, 3, 2, 1,  0,  0,  0};
    vecs[8]  = '{0, 0, 1, 1, 0,  1, 3, 2, 1,  0,  0,  0};
    vecs[9]  = '{1, 0, 1, 1, 0,  4, 6, 0, 1,  0,  0,  1};
    vecs[10] = '{1, 1, 0, 0, 0,  0, 1, 0, 0,  0,  0,  0};
    vecs[11] = '{1, 1, 1, 1, 0,  0, 1, 0, 0,  0,  0,  1};

    do_reset();
    check_all("reset", 0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].ar, vecs[i].ae, vecs[i].wr, vecs[i].le);
      check_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].tw, vecs[i].lay,
                vecs[i].last, vecs[i].done, vecs[i].we, 1'b0);
    end

    // Full pass: 11 butterflies reach layer 2 b3, the 12th wraps and pulses DONE.
    for (int k = 1; k <= 11; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'((k % BF) == 0));
    check_all("l2b3", 3, 7, 3, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_all("final wrap", 0, 1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("done drop", 0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stray LAY_EN at layer 0 b1.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("stray lay_en", 2, 3, 0, 0, 1'b0, 1'b0, 1'b0, LayChk);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("err past addr_rst", 0, 1, 0, 0, 1'b0, 1'b0, 1'b0, LayChk);
    do_reset();
    check_all("err cleared", 0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized strobes against the flat-index model.
    t = 0; mdone = 1'b0; merr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      logic r_en, r_ar, r_ae, r_wr, r_le;
      r_en = 1'($urandom_range(0, 7) != 0);
      r_ar = r_en && ($urandom_range(0, 39) == 0);
      r_ae = 1'($urandom_range(0, 3) != 0);
      r_wr = 1'($urandom_range(0, 1));
      wrap = r_en && !r_ar && r_ae && ((t % BF) == BF - 1);
      r_le = wrap && ((t + 1) != L * BF);
      if ($urandom_range(0, 31) == 0) r_le = !r_le;
      step(r_en, r_ar, r_ae, r_wr, r_le);

      if (LayChk && r_en) begin
        if (r_le && !wrap) merr = 1'b1;
        if (wrap && !r_le && ((t + 1) != L * BF)) merr = 1'b1;
      end
      if (r_ar) begin
        t = 0;
        mdone = 1'b0;
      end else if (r_en) begin
        mdone = 1'b0;
        if (r_ae) begin
          t++;
          if (t == L * BF) begin
            t = 0;
            mdone = 1'b1;
          end
        end
      end
      model_addr(t, ma, mb, mtw, mlay);
      check_all($sformatf("rand%0d", i), ma, mb, mtw, mlay, 1'(mlay == L - 1), mdone,
                r_wr & r_en, merr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
